// File: rtl/park_space_allocator.sv
// Parking-lot space allocator: grants the lowest free eligible space, holds the entry gate, frees spaces on exit.
// Optional PARK_RESERVE_EN: space 7 is reserved for VIP requests.
module park_space_allocator #(
   parameter int GATE_HOLD_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       entry_req,
   input  logic       entry_vip,
   input  logic       exit_req,
   input  logic [2:0] exit_space,
   output logic       entry_ack,
   output logic [2:0] entry_space,
   output logic       entry_reject,
   output logic       gate_open,
   output logic       exit_err,
   output logic [7:0] free_map,
   output logic [3:0] free_count,
   output logic       full,
   output logic       empty
);

   typedef enum logic [1:0] {IDLE, ALLOC, GATE, REJECT} state_t;

   state_t     state_q, state_d;
   logic [3:0] timer_q, timer_d;
   logic       vip_q, vip_d;
   logic [7:0] free_map_q, free_map_d;
   logic [3:0] free_count_q, free_count_d;
   logic [2:0] space_q, space_d;
   logic       exit_err_q, exit_err_d;

   logic [7:0] eligible;
   logic       found;
   logic [2:0] grant_idx;
   logic [7:0] alloc_clr;
   logic [7:0] exit_set;
   logic       exit_ok;

`ifdef PARK_RESERVE_EN
   assign eligible = free_map_q & (vip_q ? 8'hFF : 8'h7F);
`else
   logic unused_vip;
   assign unused_vip = vip_q;
   assign eligible   = free_map_q;
`endif

   // Scan downward so the lowest set bit wins.
   always_comb begin
      found     = 1'b0;
      grant_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (eligible[i]) begin
            found     = 1'b1;
            grant_idx = 3'(i);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      vip_d        = vip_q;
      space_d      = space_q;
      entry_ack    = 1'b0;
      entry_reject = 1'b0;
      gate_open    = 1'b0;
      alloc_clr    = 8'h00;
      case (state_q)
         IDLE: begin
            if (entry_req) begin
               vip_d   = entry_vip;
               state_d = ALLOC;
            end
         end
         ALLOC: begin
            if (found) begin
               entry_ack = 1'b1;
               space_d   = grant_idx;
               alloc_clr = 8'h01 << grant_idx;
               timer_d   = 4'(GATE_HOLD_CYCLES);
               state_d   = GATE;
            end else begin
               state_d = REJECT;
            end
         end
         GATE: begin
            gate_open = 1'b1;
            timer_d   = timer_q - 4'd1;
            if (timer_q <= 4'd1) begin
               state_d = IDLE;
            end
         end
         REJECT: begin
            entry_reject = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Exit is evaluated against the pre-edge map; a granted bit is never also an exit target.
   assign exit_ok      = exit_req & ~free_map_q[exit_space];
   assign exit_set     = exit_ok ? (8'h01 << exit_space) : 8'h00;
   assign exit_err_d   = exit_req & free_map_q[exit_space];
   assign free_map_d   = (free_map_q & ~alloc_clr) | exit_set;
   assign free_count_d = free_count_q + {3'b000, exit_ok} - {3'b000, entry_ack};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         timer_q      <= 4'd0;
         vip_q        <= 1'b0;
         free_map_q   <= 8'hFF;
         free_count_q <= 4'd8;
         space_q      <= 3'd0;
         exit_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         vip_q        <= vip_d;
         free_map_q   <= free_map_d;
         free_count_q <= free_count_d;
         space_q      <= space_d;
         exit_err_q   <= exit_err_d;
      end
   end

   assign entry_space = entry_ack ? grant_idx : space_q;
   assign exit_err    = exit_err_q;
   assign free_map    = free_map_q;
   assign free_count  = free_count_q;
   assign full        = (free_count_q == 4'd0);
   assign empty       = (free_count_q == 4'd8);

endmodule

// File: tb/tb_park_space_allocator.sv
// Directed bench for park_space_allocator: table of entry/exit operations plus hand-written corner sequences.
module tb_park_space_allocator;

   localparam int GH = 4;
   localparam int OP_REQ  = 0;
   localparam int OP_EXIT = 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       entry_req, entry_vip, exit_req;
   logic [2:0] exit_space;
   logic       entry_ack, entry_reject, gate_open, exit_err, full, empty;
   logic [2:0] entry_space;
   logic [7:0] free_map;
   logic [3:0] free_count;

   int n_checks = 0;
   int n_fail   = 0;

   park_space_allocator #(.GATE_HOLD_CYCLES(GH)) dut (
      .clk(clk), .rst_n(rst_n),
      .entry_req(entry_req), .entry_vip(entry_vip),
      .exit_req(exit_req), .exit_space(exit_space),
      .entry_ack(entry_ack), .entry_space(entry_space), .entry_reject(entry_reject),
      .gate_open(gate_open), .exit_err(exit_err),
      .free_map(free_map), .free_count(free_count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         op;
      logic       vip;
      logic       flag;     // REQ: expect grant; EXIT: expect exit_err
      logic [2:0] sp;       // REQ: expected space; EXIT: space leaving
      logic [7:0] exp_map;
      logic [3:0] exp_cnt;
   } vec_t;

   vec_t vec [0:17];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic do_req(input logic vip, input logic exp_ok, input logic [2:0] exp_sp);
      int   g, r, a;
      logic g_first, r_first;
      g = 0; r = 0; a = 0; g_first = 1'b0; r_first = 1'b0;
      @(negedge clk); entry_req = 1'b1; entry_vip = vip;
      @(negedge clk); entry_req = 1'b0; entry_vip = 1'b0;
      chk("entry_ack", 32'(entry_ack), 32'(exp_ok));
      if (exp_ok) chk("entry_space", 32'(entry_space), 32'(exp_sp));
      for (int c = 0; c < GH + 2; c++) begin
         @(negedge clk);
         if (c == 0) begin
            g_first = gate_open;
            r_first = entry_reject;
         end
         g += int'(gate_open);
         r += int'(entry_reject);
         a += int'(entry_ack);
      end
      chk("gate_cycles", 32'(g), exp_ok ? 32'(GH) : 32'd0);
      chk("reject_pulses", 32'(r), exp_ok ? 32'd0 : 32'd1);
      chk("extra_ack", 32'(a), 32'd0);
      chk("first_cycle_after_alloc", exp_ok ? 32'(g_first) : 32'(r_first), 32'd1);
      if (exp_ok) chk("entry_space_hold", 32'(entry_space), 32'(exp_sp));
   endtask

   task automatic do_exit(input logic [2:0] sp, input logic exp_err);
      @(negedge clk); exit_req = 1'b1; exit_space = sp;
      @(negedge clk); exit_req = 1'b0;
      chk("exit_err", 32'(exit_err), 32'(exp_err));
      @(negedge clk);
      chk("exit_err_pulse_end", 32'(exit_err), 32'd0);
   endtask

   task automatic chk_map(input logic [7:0] m, input logic [3:0] n);
      chk("free_map", 32'(free_map), 32'(m));
      chk("free_count", 32'(free_count), 32'(n));
      chk("full", 32'(full), 32'(n == 4'd0));
      chk("empty", 32'(empty), 32'(n == 4'd8));
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] m;
      rst_n = 1'b0; entry_req = 1'b0; entry_vip = 1'b0; exit_req = 1'b0; exit_space = 3'd0;

      // Fill 0..7, reject when full, then a mix of exits and grants.
      for (int i = 0; i < 8; i++) begin
         m = 8'hFF;
         m = m << (i + 1);
         vec[i] = '{OP_REQ, 1'b0, 1'b1, 3'(i), m, 4'(7 - i)};
      end
      vec[8]  = '{OP_REQ,  1'b0, 1'b0, 3'd0, 8'h00, 4'd0};
      vec[9]  = '{OP_EXIT, 1'b0, 1'b0, 3'd3, 8'h08, 4'd1};
      vec[10] = '{OP_REQ,  1'b0, 1'b1, 3'd3, 8'h00, 4'd0};
      vec[11] = '{OP_EXIT, 1'b0, 1'b0, 3'd5, 8'h20, 4'd1};
      vec[12] = '{OP_EXIT, 1'b0, 1'b1, 3'd5, 8'h20, 4'd1};
      vec[13] = '{OP_EXIT, 1'b0, 1'b0, 3'd0, 8'h21, 4'd2};
      vec[14] = '{OP_REQ,  1'b1, 1'b1, 3'd0, 8'h20, 4'd1};
      vec[15] = '{OP_EXIT, 1'b0, 1'b0, 3'd7, 8'hA0, 4'd2};
      vec[16] = '{OP_REQ,  1'b0, 1'b1, 3'd5, 8'h80, 4'd1};
      vec[17] = '{OP_EXIT, 1'b0, 1'b0, 3'd3, 8'h88, 4'd2};

      #12;
      chk_map(8'hFF, 4'd8);
      chk("reset_ack", 32'(entry_ack), 32'd0);
      chk("reset_reject", 32'(entry_reject), 32'd0);
      chk("reset_gate", 32'(gate_open), 32'd0);
      chk("reset_exit_err", 32'(exit_err), 32'd0);
      chk("reset_space", 32'(entry_space), 32'd0);
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         if (vec[i].op == OP_REQ) do_req(vec[i].vip, vec[i].flag, vec[i].sp);
         else                     do_exit(vec[i].sp, vec[i].flag);
         chk_map(vec[i].exp_map, vec[i].exp_cnt);
      end

      // Exit of space 2 lands on the ALLOC edge; space 3 is the lowest free.
      @(negedge clk); entry_req = 1'b1;
      @(negedge clk); entry_req = 1'b0; exit_req = 1'b1; exit_space = 3'd2;
      chk("same_cycle_ack", 32'(entry_ack), 32'd1);
      chk("same_cycle_space", 32'(entry_space), 32'd3);
      @(negedge clk); exit_req = 1'b0;
      chk_map(8'h84, 4'd2);
      chk("same_cycle_gate", 32'(gate_open), 32'd1);
      chk("same_cycle_exit_err", 32'(exit_err), 32'd0);
      repeat (GH + 2) @(negedge clk);

      // Async reset while the gate is open.
      @(negedge clk); entry_req = 1'b1;
      @(negedge clk); entry_req = 1'b0;
      @(negedge clk);
      chk("gate_before_reset", 32'(gate_open), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("gate_after_reset", 32'(gate_open), 32'd0);
      chk("space_after_reset", 32'(entry_space), 32'd0);
      chk_map(8'hFF, 4'd8);
      @(negedge clk); rst_n = 1'b1;

      // Only space 7 left free.
      for (int i = 0; i < 7; i++) do_req(1'b0, 1'b1, 3'(i));
      chk_map(8'h80, 4'd1);
`ifdef PARK_RESERVE_EN
      do_req(1'b0, 1'b0, 3'd0);
      chk_map(8'h80, 4'd1);
      do_req(1'b1, 1'b1, 3'd7);
`else
      do_req(1'b0, 1'b1, 3'd7);
`endif
      chk_map(8'h00, 4'd0);

      // Exit on the ALLOC edge of a full lot does not rescue the request.
      @(negedge clk); entry_req = 1'b1; entry_vip = 1'b1;
      @(negedge clk); entry_req = 1'b0; entry_vip = 1'b0; exit_req = 1'b1; exit_space = 3'd4;
      chk("full_alloc_ack", 32'(entry_ack), 32'd0);
      @(negedge clk); exit_req = 1'b0;
      chk("full_alloc_reject", 32'(entry_reject), 32'd1);
      chk_map(8'h10, 4'd1);
      repeat (3) @(negedge clk);

      apply_reset();
      chk_map(8'hFF, 4'd8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/park_space_allocator.md
# park_space_allocator

Sequential allocator that owns the occupancy state of the 8-space lot. It accepts car-entry requests, grants the lowest-numbered free space, and drives the entry gate for a fixed hold time. It also releases spaces on car exit. Its registered `free_map` output feeds the `parking_capacity` input of the downstream space-number encoder.

## Interface
Parameters:
- `GATE_HOLD_CYCLES`, default 4: cycles `gate_open` stays high after a grant. Legal range 1..15.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `entry_req` in 1: car waiting at the entry. Level signal, sampled only in IDLE.
- `entry_vip` in 1: priority qualifier for `entry_req`. Meaningful only with `PARK_RESERVE_EN`.
- `exit_req` in 1: one-cycle pulse; a car is leaving space `exit_space`.
- `exit_space` in 3: index of the space being vacated.
- `entry_ack` out 1: one-cycle pulse; a space was granted.
- `entry_space` out 3: granted index. Valid while `entry_ack` is high; holds its value afterwards.
- `entry_reject` out 1: one-cycle pulse; no eligible free space.
- `gate_open` out 1: entry gate drive.
- `exit_err` out 1: one-cycle pulse; exit for a space that was already free.
- `free_map` out 8: bit i = 1 means space i is free.
- `free_count` out 4: number of free spaces, 0..8.
- `full` out 1: `free_count == 0`.
- `empty` out 1: `free_count == 8`.

## Operation
- FSM states: IDLE, ALLOC, GATE, REJECT.
- IDLE: if `entry_req` is 1, latch `entry_vip` and go to ALLOC.
- ALLOC: search the current registered `free_map` for the lowest set bit among the eligible spaces.
  - If one is found: pulse `entry_ack`, drive `entry_space`, clear that bit, decrement `free_count`, load the gate timer with `GATE_HOLD_CYCLES`, go to GATE.
  - If none is found: go to REJECT.
- GATE: `gate_open` = 1. Decrement the timer each cycle; return to IDLE when it reaches 0.
- REJECT: pulse `entry_reject` for one cycle, then return to IDLE.
- `entry_req` still high on return to IDLE starts a new request. This is intentional: the next car is served.
- Exit handling is independent of FSM state and is processed in every state, including GATE.
  - If `free_map[exit_space]` is 0: set it and increment `free_count`.
  - Otherwise: pulse `exit_err` next cycle and change no other state.
- Exit and allocation in the same cycle: both updates apply at the same edge.
  - `free_count` net change is 0.
  - Allocation sees the pre-exit `free_map`, so an exit never rescues a same-cycle reject.
- `full` and `empty` are decoded combinationally from the registered `free_count`.
- Invariant: `free_count` always equals popcount(`free_map`). `free_count` can never wrap.

## Timing
- Reset values: `free_map` = 8'hFF, `free_count` = 8, `empty` = 1, `full` = 0. All pulses, `gate_open`, and `entry_space` = 0. FSM in IDLE.
- Reset asserted mid-operation clears everything immediately, asynchronously, including an open gate.
- Latency, grant path: `entry_req` sampled high at edge N in IDLE → `entry_ack` high in cycle N+1.
  - `free_map` update visible in cycle N+2.
  - `gate_open` high in cycles N+2 .. N+1+`GATE_HOLD_CYCLES`.
- Latency, reject path: `entry_reject` high in cycle N+2.
- Latency, exit path: `exit_req` at edge M → updated `free_map`/`free_count`, or `exit_err`, in cycle M+1.
- Minimum spacing between grants: `GATE_HOLD_CYCLES` + 2 cycles.

## Configuration
- `PARK_RESERVE_EN` defined: space 7 is reserved.
  - A non-VIP request is eligible for spaces 0..6 only.
  - A VIP request searches 0..7, lowest first.
  - A non-VIP request with only space 7 free is rejected.
- `PARK_RESERVE_EN` undefined: `entry_vip` is ignored and all eight spaces are eligible for every request.

## Test plan
- Reset, then `entry_req` for one cycle: `entry_ack` with `entry_space` = 0; `free_map` = 8'hFE; `free_count` = 7; `gate_open` high for exactly 4 cycles.
- Fill all 8 spaces, then one more request: `entry_space` sequence 0..7; `full` = 1; `entry_reject` pulses; `free_map` stays 8'h00.
- From full, `exit_space` = 3: `free_map` = 8'h08. Next request grants space 3.
- `exit_req` on an already-free space 5: `exit_err` pulses; `free_map` and `free_count` unchanged.
- Exit of space 2 in the same cycle as ALLOC (spaces 0..1 occupied, 2 occupied, 3 free): grant = 3, space 2 freed, `free_count` unchanged.
- With `PARK_RESERVE_EN` and only space 7 free: non-VIP request → reject; VIP request → `entry_space` = 7. Reset asserted during GATE → `gate_open` drops immediately and `free_map` = 8'hFF.
